dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between the CPU core and a
//   loader/debug port. The core is frozen through `stall` while its access
//   is pending. The loader uses a request / done handshake. When both ports
//   ask in the same IDLE cycle, the port that was not served last wins.
//
//   Ports
//     clk, rst            clock, asynchronous active-low reset
//     core_rd, core_wr    core load / store request (store wins if both high)
//     core_addr           core word address
//     core_wdata          core store data
//     core_rdata          core load data, valid in the cycle stall drops
//     stall               freezes the core while its request is outstanding
//     ld_req, ld_wr       loader request (held until ld_done) and access type
//     ld_addr, ld_wdata   loader word address / write data
//     ld_rdata, ld_done   loader read data, valid with the one-cycle done pulse
//     mem_en, mem_we      memory access strobe / write enable
//     mem_addr, mem_wdata memory address / write data (registered)
//     mem_rdata           memory read data, valid in the last access cycle
module dmem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              stall,
  input  logic              ld_req,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Value of the access counter in the final access cycle.
  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CORE_ACC,
    CORE_DONE,
    LD_ACC,
    LD_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        last_ld;     // 1: the loader was served last, so the core wins a tie
  logic        acc_we;      // registered access type of the running access
  logic        core_req;
  logic        grant_core;
  logic        grant_ld;
  logic        acc_last;
  logic        in_acc;

  assign core_req = core_rd | core_wr;
  assign acc_last = (cnt == CNT_LAST);
  assign in_acc   = (state == CORE_ACC) || (state == LD_ACC);

  // Next-state and grant decode
  always_comb begin
    state_nx   = state;
    grant_core = 1'b0;
    grant_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (core_req && (!ld_req || last_ld)) begin
          state_nx   = CORE_ACC;
          grant_core = 1'b1;
        end else if (ld_req) begin
          state_nx = LD_ACC;
          grant_ld = 1'b1;
        end
      end
      CORE_ACC: begin
        if (acc_last) begin
          state_nx = CORE_DONE;
        end
      end
      LD_ACC: begin
        if (acc_last) begin
          state_nx = LD_DONE;
        end
      end
      CORE_DONE: state_nx = IDLE;
      LD_DONE:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Status and memory strobes. The async reset pin gates stall so that a
  // core request that is already held during reset never reaches the core
  // as a stall.
  always_comb begin
    mem_en  = in_acc;
    mem_we  = in_acc && acc_we;
    ld_done = (state == LD_DONE);
    stall   = rst && core_req && (state != CORE_DONE);
  end

  // State, access counter and arbitration history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last_ld <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant_core || grant_ld) begin
        cnt <= 4'd0;
      end else if (in_acc) begin
        cnt <= acc_last ? 4'd0 : cnt + 4'd1;
      end
      if (state == CORE_DONE) begin
        last_ld <= 1'b0;
      end else if (state == LD_DONE) begin
        last_ld <= 1'b1;
      end
    end
  end

  // Access request register: the granted port's address, data and type are
  // frozen here for the whole access, so the inputs may move freely
  // afterwards. The register keeps its value after the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      acc_we    <= 1'b0;
    end else if (grant_core) begin
      mem_addr  <= core_addr;
      mem_wdata <= core_wdata;
      acc_we    <= core_wr;
    end else if (grant_ld) begin
      mem_addr  <= ld_addr;
      mem_wdata <= ld_wdata;
      acc_we    <= ld_wr;
    end
  end

  // Read-data capture on the final access cycle. Writes leave the
  // previously captured value untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rdata <= '0;
      ld_rdata   <= '0;
    end else if (acc_last && !acc_we) begin
      if (state == CORE_ACC) begin
        core_rdata <= mem_rdata;
      end
      if (state == LD_ACC) begin
        ld_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Random and directed traffic for dmem_arbiter (MEM_LAT=4), plus a
//   MEM_LAT=1 instance for back-to-back core loads. The expected behaviour
//   comes from a transaction-level model. That model tracks the memory
//   contents, which port was served last, and the completion time of each
//   access as plain arithmetic in MEM_LAT.
module tb_dmem_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          core_rd, core_wr, stall, ld_req, ld_wr, ld_done, mem_en, mem_we;
  logic [AW-1:0] core_addr, ld_addr, mem_addr;
  logic [DW-1:0] core_wdata, core_rdata, ld_wdata, ld_rdata, mem_wdata, mem_rdata;

  logic          core_rd1, core_wr1, stall1, ld_req1, ld_wr1, ld_done1, mem_en1, mem_we1;
  logic [AW-1:0] core_addr1, ld_addr1, mem_addr1;
  logic [DW-1:0] core_wdata1, core_rdata1, ld_wdata1, ld_rdata1, mem_wdata1, mem_rdata1;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .stall(stall),
    .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .core_rd(core_rd1), .core_wr(core_wr1), .core_addr(core_addr1), .core_wdata(core_wdata1),
    .core_rdata(core_rdata1), .stall(stall1),
    .ld_req(ld_req1), .ld_wr(ld_wr1), .ld_addr(ld_addr1), .ld_wdata(ld_wdata1),
    .ld_rdata(ld_rdata1), .ld_done(ld_done1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  // Memory environment: contents live in phys_mem. Read data is only valid
  // in the last access cycle; every other cycle returns a poison pattern.
  logic [DW-1:0] phys_mem [0:1023];
  logic [DW-1:0] ref_mem  [0:1023];
  int            acc_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst)        acc_cnt <= 0;
    else if (mem_en) acc_cnt <= acc_cnt + 1;
    else             acc_cnt <= 0;
  end

  assign mem_rdata  = (mem_en && !mem_we && acc_cnt == LAT - 1) ? phys_mem[mem_addr]
                                                                : (32'hBAD0_0000 | 32'(acc_cnt));
  assign mem_rdata1 = mem_en1 ? {16'hC0DE, 6'h00, mem_addr1} : 32'hBAD1_BAD1;

  int            n_vec = 0;
  int            n_err = 0;
  bit            last_ld_m;
  logic [DW-1:0] exp_core_q, exp_ld_q;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Commits a write to phys_mem on the last cycle of a write access.
  task automatic mem_tick();
    if (mem_en && mem_we && acc_cnt == LAT - 1) phys_mem[mem_addr] = mem_wdata;
  endtask

  // One arbitration round. It starts at a negedge with the DUT in IDLE.
  // Both requests are raised together. Every port that is not requesting
  // has its data lines scrambled each cycle.
  task automatic run_round(input logic crd, input logic cwr, input logic [AW-1:0] ca,
                           input logic [DW-1:0] cd, input logic lreq, input logic lwr,
                           input logic [AW-1:0] la, input logic [DW-1:0] ldat);
    bit hc, core_first, in_c, in_l;
    int t_core, t_ld, last_t;
    hc         = crd | cwr;
    core_first = hc && (!lreq || last_ld_m);
    t_core     = -1;
    t_ld       = -1;
    if (hc && lreq) begin
      t_core = core_first ? LAT + 1 : 2 * LAT + 3;
      t_ld   = core_first ? 2 * LAT + 3 : LAT + 1;
    end else if (hc) begin
      t_core = LAT + 1;
    end else if (lreq) begin
      t_ld = LAT + 1;
    end
    // Transaction-level effect on memory, applied in service order.
    if (core_first) begin
      if (cwr) ref_mem[ca] = cd; else if (crd) exp_core_q = ref_mem[ca];
      if (lreq) begin if (lwr) ref_mem[la] = ldat; else exp_ld_q = ref_mem[la]; end
    end else begin
      if (lreq) begin if (lwr) ref_mem[la] = ldat; else exp_ld_q = ref_mem[la]; end
      if (cwr) ref_mem[ca] = cd; else if (crd) exp_core_q = ref_mem[ca];
    end
    if (hc && lreq) last_ld_m = core_first;
    else if (hc)    last_ld_m = 1'b0;
    else if (lreq)  last_ld_m = 1'b1;
    last_t = ((t_core > t_ld) ? t_core : t_ld) + 1;
    if (last_t < 1) last_t = 1;

    core_rd = crd; core_wr = cwr;
    core_addr  = hc ? ca : AW'($urandom);
    core_wdata = hc ? cd : $urandom;
    ld_req = lreq;
    ld_wr      = lreq ? lwr  : 1'($urandom);
    ld_addr    = lreq ? la   : AW'($urandom);
    ld_wdata   = lreq ? ldat : $urandom;
    #1;
    for (int t = 0; t <= last_t; t++) begin
      if (t > 0) @(negedge clk);
      in_c = hc   && t >= t_core - LAT && t < t_core;
      in_l = lreq && t >= t_ld - LAT   && t < t_ld;
      chk("stall",   32'(stall),   32'(hc && t < t_core));
      chk("ld_done", 32'(ld_done), 32'(lreq && t == t_ld));
      chk("mem_en",  32'(mem_en),  32'(in_c || in_l));
      chk("mem_we",  32'(mem_we),  32'((in_c && cwr) || (in_l && lwr)));
      if (in_c) begin
        chk("mem_addr_core", 32'(mem_addr), 32'(ca));
        if (cwr) chk("mem_wdata_core", mem_wdata, cd);
      end
      if (in_l) begin
        chk("mem_addr_ld", 32'(mem_addr), 32'(la));
        if (lwr) chk("mem_wdata_ld", mem_wdata, ldat);
      end
      if (hc && t == t_core)  chk("core_rdata", core_rdata, exp_core_q);
      if (lreq && t == t_ld)  chk("ld_rdata",   ld_rdata,   exp_ld_q);
      if (t == last_t) begin
        chk("core_rdata_hold", core_rdata, exp_core_q);
        chk("ld_rdata_hold",   ld_rdata,   exp_ld_q);
      end
      mem_tick();
      if (hc && t == t_core) begin core_rd = 1'b0; core_wr = 1'b0; end
      if (lreq && t == t_ld) ld_req = 1'b0;
      if (!hc) begin core_addr = AW'($urandom); core_wdata = $urandom; end
      if (!lreq || t >= t_ld) begin
        ld_wr = 1'($urandom); ld_addr = AW'($urandom); ld_wdata = $urandom;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int            cop, lop;
    for (int i = 0; i < 1024; i++) begin
      phys_mem[i] = {16'h5EED, 6'h00, 10'(i)};
      ref_mem[i]  = {16'h5EED, 6'h00, 10'(i)};
    end
    phys_mem[10'h010] = 32'hDEADBEEF;
    ref_mem[10'h010]  = 32'hDEADBEEF;
    exp_core_q = '0; exp_ld_q = '0; last_ld_m = 1'b1;

    rst = 1'b0;
    core_rd = 1'b1; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
    ld_req = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_wdata = '0;
    core_rd1 = 1'b0; core_wr1 = 1'b0; core_addr1 = '0; core_wdata1 = '0;
    ld_req1 = 1'b0; ld_wr1 = 1'b0; ld_addr1 = '0; ld_wdata1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall",      32'(stall),     32'd0);
    chk("rst_mem_en",     32'(mem_en),    32'd0);
    chk("rst_mem_we",     32'(mem_we),    32'd0);
    chk("rst_ld_done",    32'(ld_done),   32'd0);
    chk("rst_core_rdata", core_rdata,     32'd0);
    chk("rst_ld_rdata",   ld_rdata,       32'd0);
    chk("rst_mem_addr",   32'(mem_addr),  32'd0);
    chk("rst_mem_wdata",  mem_wdata,      32'd0);
    core_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Two same-cycle ties right after reset: core, loader, then core again.
    @(negedge clk); run_round(1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 1'b0, 10'h3FF, 32'h0);
    @(negedge clk); run_round(1'b1, 1'b0, 10'h011, 32'h0, 1'b1, 1'b0, 10'h012, 32'h0);
    // Plain core load, core store at the top address.
    @(negedge clk); run_round(1'b1, 1'b0, 10'h010, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0);
    @(negedge clk); run_round(1'b0, 1'b1, 10'h3FF, 32'h12345678, 1'b0, 1'b0, 10'h000, 32'h0);
    // Loader write then read back.
    @(negedge clk); run_round(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 10'h020, 32'hA5A5A5A5);
    @(negedge clk); run_round(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h020, 32'h0);

    // Reset in the 2nd loader access cycle, then a full restart.
    @(negedge clk);
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 10'h030; ld_wdata = 32'h0BADF00D;
    @(negedge clk);
    chk("abort_mem_en_c1", 32'(mem_en), 32'd1);
    mem_tick();
    @(negedge clk);
    chk("abort_mem_en_c2", 32'(mem_en), 32'd1);
    mem_tick();
    rst = 1'b0;
    #1;
    chk("abort_mem_en",     32'(mem_en),   32'd0);
    chk("abort_mem_we",     32'(mem_we),   32'd0);
    chk("abort_ld_done",    32'(ld_done),  32'd0);
    chk("abort_mem_addr",   32'(mem_addr), 32'd0);
    chk("abort_core_rdata", core_rdata,    32'd0);
    exp_core_q = '0; exp_ld_q = '0; last_ld_m = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run_round(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 10'h030, 32'h0BADF00D);
    @(negedge clk); run_round(1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h030, 32'h0);

    // Randomized traffic.
    for (int r = 0; r < 200; r++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_stall",  32'(stall),  32'd0);
        chk("gap_mem_en", 32'(mem_en), 32'd0);
      end
      cop = $urandom_range(0, 3);
      lop = $urandom_range(0, 2);
      a   = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'h010 + AW'($urandom_range(0, 7));
      d   = $urandom;
      @(negedge clk);
      run_round(cop[0], cop[1], a, d, lop != 0, lop == 2,
                10'h010 + AW'($urandom_range(0, 7)), $urandom);
    end

    // MEM_LAT=1: four back-to-back core loads with core_rd held high.
    @(negedge clk);
    core_rd1 = 1'b1;
    core_addr1 = 10'h100;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      chk("lat1_stall",  32'(stall1),  32'(c % 3 != 2));
      chk("lat1_mem_en", 32'(mem_en1), 32'(c % 3 == 1));
      if (c % 3 == 2) begin
        chk("lat1_rdata", core_rdata1, {16'hC0DE, 6'h00, core_addr1});
        core_addr1 = core_addr1 + 10'h005;
        if (c == 11) core_rd1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("lat1_idle_stall", 32'(stall1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
